trace_commit_buffer: RTL and testbench

TRACE_COMMIT_BUFFER -- requirements
Module: trace_commit_buffer

---
 rtl/trace_commit_buffer.sv | 88 ++++++++
 tb/tb_trace_commit_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_commit_buffer.sv
// trace_commit_buffer: show-ahead FIFO of retired-instruction records, each stamped with an instruction number.
module trace_commit_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmt_valid,
  output logic                       cmt_ready,
  input  logic [15:0]                cmt_pc,
  input  logic [15:0]                cmt_inst,
  input  logic                       cmt_regWrt,
  input  logic [2:0]                 cmt_wrReg,
  input  logic [15:0]                cmt_wrData,
  input  logic                       cmt_memRead,
  input  logic                       cmt_memWrt,
  input  logic [15:0]                cmt_memAddr,
  input  logic [15:0]                cmt_memData,
  input  logic                       cmt_halt,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [15:0]                trc_pc,
  output logic [15:0]                trc_inst,
  output logic                       trc_regWrt,
  output logic [2:0]                 trc_wrReg,
  output logic [15:0]                trc_wrData,
  output logic                       trc_memRead,
  output logic                       trc_memWrt,
  output logic [15:0]                trc_memAddr,
  output logic [15:0]                trc_memData,
  output logic                       trc_halt,
  output logic [15:0]                trc_inum,
  output logic                       halted,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [102:0] mem_q [DEPTH];
  logic [102:0] head;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] count_q, count_d;
  logic [15:0] inum_q, inum_d;
  logic halt_seen_q, halt_seen_d, halted_q, halted_d, overflow_q, overflow_d;
  logic enq, deq;
  assign head = mem_q[rp_q];
  assign {trc_pc, trc_inst, trc_regWrt, trc_wrReg, trc_wrData, trc_memRead, trc_memWrt,
          trc_memAddr, trc_memData, trc_halt, trc_inum} = head;
  assign count = count_q;
  assign halted = halted_q;
  assign overflow = overflow_q;
  // rst gates ready so nothing is accepted while reset is held
  always_comb begin
    cmt_ready = !rst && (count_q != (AW+1)'(DEPTH)) && !halt_seen_q;
    trc_valid = count_q != '0;
    enq = cmt_valid && cmt_ready;
    deq = trc_valid && trc_ready;
    wp_d = enq ? wp_q + AW'(1) : wp_q;
    rp_d = deq ? rp_q + AW'(1) : rp_q;
    count_d = count_q + (AW+1)'(enq) - (AW+1)'(deq);
    inum_d = enq ? inum_q + 16'd1 : inum_q;
    halt_seen_d = halt_seen_q || (enq && cmt_halt);
    halted_d = halted_q || (deq && trc_halt);
    overflow_d = overflow_q || (cmt_valid && !cmt_ready);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
      inum_q <= '0;
      halt_seen_q <= 1'b0;
      halted_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      count_q <= count_d;
      inum_q <= inum_d;
      halt_seen_q <= halt_seen_d;
      halted_q <= halted_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq)
      mem_q[wp_q] <= {cmt_pc, cmt_inst, cmt_regWrt, cmt_wrReg, cmt_wrData, cmt_memRead, cmt_memWrt,
                      cmt_memAddr, cmt_memData, cmt_halt, inum_q};
  end
endmodule

// File: tb/tb_trace_commit_buffer.sv
// tb_trace_commit_buffer: directed and randomized checks against a queue-based reference model.
module tb_trace_commit_buffer;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0;
  logic cmt_valid = 0, cmt_ready, trc_valid, trc_ready = 0;
  logic [15:0] cmt_pc, cmt_inst, cmt_wrData, cmt_memAddr, cmt_memData;
  logic cmt_regWrt, cmt_memRead, cmt_memWrt, cmt_halt;
  logic [2:0] cmt_wrReg;
  logic [15:0] trc_pc, trc_inst, trc_wrData, trc_memAddr, trc_memData, trc_inum;
  logic trc_regWrt, trc_memRead, trc_memWrt, trc_halt, halted, overflow;
  logic [2:0] trc_wrReg;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed {
    logic [15:0] pc, inst;
    logic regWrt;
    logic [2:0] wrReg;
    logic [15:0] wrData;
    logic memRead, memWrt;
    logic [15:0] memAddr, memData;
    logic halt;
    logic [15:0] inum;
  } rec_t;

  rec_t q[$];
  rec_t got;
  logic [15:0] m_inum;
  bit m_hs, m_halted, m_ovf;
  int checks = 0, errors = 0;

  assign got = {trc_pc, trc_inst, trc_regWrt, trc_wrReg, trc_wrData, trc_memRead, trc_memWrt,
                trc_memAddr, trc_memData, trc_halt, trc_inum};

  trace_commit_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmt_valid(cmt_valid), .cmt_ready(cmt_ready),
    .cmt_pc(cmt_pc), .cmt_inst(cmt_inst), .cmt_regWrt(cmt_regWrt), .cmt_wrReg(cmt_wrReg),
    .cmt_wrData(cmt_wrData), .cmt_memRead(cmt_memRead), .cmt_memWrt(cmt_memWrt),
    .cmt_memAddr(cmt_memAddr), .cmt_memData(cmt_memData), .cmt_halt(cmt_halt),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_pc(trc_pc), .trc_inst(trc_inst),
    .trc_regWrt(trc_regWrt), .trc_wrReg(trc_wrReg), .trc_wrData(trc_wrData),
    .trc_memRead(trc_memRead), .trc_memWrt(trc_memWrt), .trc_memAddr(trc_memAddr),
    .trc_memData(trc_memData), .trc_halt(trc_halt), .trc_inum(trc_inum),
    .halted(halted), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic rand_rec(input bit h);
    cmt_pc = 16'($urandom); cmt_inst = 16'($urandom); cmt_regWrt = 1'($urandom);
    cmt_wrReg = 3'($urandom); cmt_wrData = 16'($urandom); cmt_memRead = 1'($urandom);
    cmt_memWrt = 1'($urandom); cmt_memAddr = 16'($urandom); cmt_memData = 16'($urandom);
    cmt_halt = h;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; cmt_valid = 0; trc_ready = 0;
    q.delete(); m_inum = 0; m_hs = 0; m_halted = 0; m_ovf = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic step(input bit v, input bit rdy);
    bit e, d;
    cmt_valid = v; trc_ready = rdy;
    e = v && q.size() < DEPTH && !m_hs;
    d = q.size() != 0 && rdy;
    @(posedge clk);
    if (d) begin
      if (q[0].halt) m_halted = 1;
      void'(q.pop_front());
    end
    if (e) begin
      q.push_back('{cmt_pc, cmt_inst, cmt_regWrt, cmt_wrReg, cmt_wrData, cmt_memRead, cmt_memWrt,
                    cmt_memAddr, cmt_memData, cmt_halt, m_inum});
      if (cmt_halt) m_hs = 1;
      m_inum++;
    end else if (v) m_ovf = 1;
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #2;
    checks += 5;
    if (count !== 0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    if (trc_valid !== 0) begin errors++; $display("FAIL reset_trc_valid got %b exp 0", trc_valid); end
    if (cmt_ready !== 0) begin errors++; $display("FAIL reset_cmt_ready got %b exp 0", cmt_ready); end
    if (overflow !== 0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    if (halted !== 0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    @(negedge clk); rst = 0;
    q.delete(); m_inum = 0; m_hs = 0; m_halted = 0; m_ovf = 0;
    #1; checks++;
    if (cmt_ready !== 1) begin errors++; $display("FAIL release_cmt_ready got %b exp 1", cmt_ready); end
  endtask

  task automatic test_single();
    do_reset();
    rand_rec(0);
    cmt_pc = 16'h0000; cmt_inst = 16'hC001; cmt_regWrt = 1; cmt_wrReg = 1; cmt_wrData = 16'h0005;
    cmt_memRead = 0; cmt_memWrt = 0;
    step(1, 1);
    checks += 3;
    if (trc_valid !== 1) begin errors++; $display("FAIL single_valid got %b exp 1", trc_valid); end
    if (trc_inum !== 16'd0) begin errors++; $display("FAIL single_inum got %h exp 0000", trc_inum); end
    if (trc_wrData !== 16'h0005) begin errors++; $display("FAIL single_wrData got %h exp 0005", trc_wrData); end
    step(0, 1);
    checks++;
    if (count !== 0) begin errors++; $display("FAIL single_drain_count got %0d exp 0", count); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin rand_rec(0); step(1, 0); end
    checks += 3;
    if (cmt_ready !== 0) begin errors++; $display("FAIL fill_ready got %b exp 0", cmt_ready); end
    if (count !== DEPTH) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, DEPTH); end
    if (overflow !== 0) begin errors++; $display("FAIL fill_pre_overflow got %b exp 0", overflow); end
    rand_rec(0); step(1, 1);
    checks += 2;
    if (overflow !== 1) begin errors++; $display("FAIL fill_overflow got %b exp 1", overflow); end
    if (count !== DEPTH - 1) begin errors++; $display("FAIL fill_full_deq_count got %0d exp %0d", count, DEPTH - 1); end
    for (int i = 1; i < DEPTH; i++) begin
      checks += 2;
      if (trc_inum !== 16'(i)) begin errors++; $display("FAIL fill_drain_inum got %0d exp %0d", trc_inum, i); end
      if (got !== q[0]) begin errors++; $display("FAIL fill_drain_rec got %h exp %h", got, q[0]); end
      step(0, 1);
    end
    checks++;
    if (trc_valid !== 0) begin errors++; $display("FAIL fill_empty_valid got %b exp 0", trc_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prev;
    do_reset();
    rand_rec(0); step(1, 0);
    rand_rec(0); step(1, 0);
    prev = trc_inum;
    for (int i = 0; i < 20; i++) begin
      rand_rec(0); step(1, 1);
      checks += 4;
      if (count !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", count); end
      if (trc_inum !== prev + 16'd1) begin errors++; $display("FAIL b2b_inum got %0d exp %0d", trc_inum, prev + 16'd1); end
      if (overflow !== 0) begin errors++; $display("FAIL b2b_overflow got %b exp 0", overflow); end
      if (got !== q[0]) begin errors++; $display("FAIL b2b_rec got %h exp %h", got, q[0]); end
      prev = trc_inum;
    end
  endtask

  task automatic test_halt();
    do_reset();
    rand_rec(0); cmt_memWrt = 1; cmt_memAddr = 16'h0010; cmt_memData = 16'hBEEF;
    step(1, 0);
    rand_rec(1); step(1, 0);
    checks += 2;
    if (cmt_ready !== 0) begin errors++; $display("FAIL halt_ready got %b exp 0", cmt_ready); end
    if (trc_memData !== 16'hBEEF) begin errors++; $display("FAIL halt_store_data got %h exp beef", trc_memData); end
    step(0, 1);
    checks += 3;
    if (halted !== 0) begin errors++; $display("FAIL halt_early got %b exp 0", halted); end
    if (trc_halt !== 1) begin errors++; $display("FAIL halt_head got %b exp 1", trc_halt); end
    if (count !== 1) begin errors++; $display("FAIL halt_count got %0d exp 1", count); end
    step(0, 1);
    checks += 2;
    if (halted !== 1) begin errors++; $display("FAIL halted got %b exp 1", halted); end
    if (overflow !== 0) begin errors++; $display("FAIL halt_no_overflow got %b exp 0", overflow); end
    rand_rec(0); step(1, 1);
    checks += 3;
    if (overflow !== 1) begin errors++; $display("FAIL halt_overflow got %b exp 1", overflow); end
    if (count !== 0) begin errors++; $display("FAIL halt_drop_count got %0d exp 0", count); end
    if (halted !== 1) begin errors++; $display("FAIL halted_sticky got %b exp 1", halted); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin rand_rec(0); step(1, 0); end
    checks++;
    if (count !== 3) begin errors++; $display("FAIL mid_count got %0d exp 3", count); end
    #1 rst = 1;
    #1;
    checks += 2;
    if (trc_valid !== 0) begin errors++; $display("FAIL mid_async_valid got %b exp 0", trc_valid); end
    if (count !== 0) begin errors++; $display("FAIL mid_async_count got %0d exp 0", count); end
    @(negedge clk); rst = 0; cmt_valid = 0;
    q.delete(); m_inum = 0; m_hs = 0; m_halted = 0; m_ovf = 0;
    step(0, 1);
    checks++;
    if (trc_valid !== 0) begin errors++; $display("FAIL mid_stale_valid got %b exp 0", trc_valid); end
    rand_rec(0); step(1, 0);
    checks += 3;
    if (trc_inum !== 0) begin errors++; $display("FAIL mid_first_inum got %0d exp 0", trc_inum); end
    if (count !== 1) begin errors++; $display("FAIL mid_first_count got %0d exp 1", count); end
    if (got !== q[0]) begin errors++; $display("FAIL mid_first_rec got %h exp %h", got, q[0]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_rec($urandom_range(127) == 0);
      step($urandom_range(3) != 0, 1'($urandom));
      checks += 5;
      if (count !== q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", count, q.size()); end
      if (cmt_ready !== (q.size() < DEPTH && !m_hs)) begin errors++; $display("FAIL rnd_ready got %b", cmt_ready); end
      if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow got %b exp %b", overflow, m_ovf); end
      if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted got %b exp %b", halted, m_halted); end
      if (trc_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid got %b", trc_valid); end
      if (q.size() != 0) begin
        checks++;
        if (got !== q[0]) begin errors++; $display("FAIL rnd_rec got %h exp %h", got, q[0]); end
      end
    end
  endtask

  task automatic test_wrap();
    bit seen_ffff, wrapped;
    seen_ffff = 0; wrapped = 0;
    do_reset();
    for (int i = 0; i < 32'h10005; i++) begin
      rand_rec(0); step(1, 1);
      checks++;
      if (trc_valid !== 1 || trc_inum !== q[0].inum) begin
        errors++; $display("FAIL wrap_inum got %h exp %h", trc_inum, q[0].inum);
      end
      if (seen_ffff && trc_inum === 16'h0000) wrapped = 1;
      seen_ffff = trc_inum === 16'hFFFF;
    end
    checks++;
    if (!wrapped) begin errors++; $display("FAIL wrap_seen got 0 exp 1"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
